// File: rtl/button_pkg.sv
// button_pkg: shared definitions for the button debouncer.
//   - btn_state_t : 2-bit per-channel FSM state encoding
//   - DEF_*       : default parameter values for button_debounce
//   - cnt_width() : counter width able to hold 0..max_value, never below 1 bit
package button_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } btn_state_t;

    localparam int DEF_N_CH            = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_HOLD_CYCLES     = 1000;
    localparam int DEF_REPEAT_CYCLES   = 200;

    function automatic int cnt_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/button_channel.sv
// button_channel: one debounced button.
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset
//   button_i   : raw asynchronous button level
//   level_o    : debounced level (high in PRESSED and DB_RELEASE)
//   press_o    : one-cycle pulse on an accepted press
//   release_o  : one-cycle pulse on an accepted release
//   long_o     : one-cycle pulse when the press has lasted HOLD_CYCLES
//   repeat_o   : one-cycle pulse every REPEAT_CYCLES after long_o (0 disables)
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic button_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int HW = cnt_width(HOLD_CYCLES);
    localparam int RW = cnt_width(REPEAT_CYCLES);

    localparam logic [DW-1:0] DB_ONE    = DW'(1);
    localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST  = (REPEAT_CYCLES > 0) ? RW'(REPEAT_CYCLES - 1) : '0;

    logic          sync1_reg, sync2_reg;
    btn_state_t    state_reg, state_next;
    logic [DW-1:0] db_cnt_reg, db_cnt_next;
    logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
    logic [RW-1:0] rep_cnt_reg, rep_cnt_next;
    logic          level_reg, level_next;
    logic          press_reg, press_next;
    logic          release_reg, release_next;
    logic          long_reg, long_next;
    logic          repeat_reg, repeat_next;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_reg    <= 1'b0;
            sync2_reg    <= 1'b0;
            state_reg    <= IDLE;
            db_cnt_reg   <= '0;
            hold_cnt_reg <= '0;
            rep_cnt_reg  <= '0;
            level_reg    <= 1'b0;
            press_reg    <= 1'b0;
            release_reg  <= 1'b0;
            long_reg     <= 1'b0;
            repeat_reg   <= 1'b0;
        end else begin
            sync1_reg    <= button_i;
            sync2_reg    <= sync1_reg;
            state_reg    <= state_next;
            db_cnt_reg   <= db_cnt_next;
            hold_cnt_reg <= hold_cnt_next;
            rep_cnt_reg  <= rep_cnt_next;
            level_reg    <= level_next;
            press_reg    <= press_next;
            release_reg  <= release_next;
            long_reg     <= long_next;
            repeat_reg   <= repeat_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        db_cnt_next   = db_cnt_reg;
        hold_cnt_next = hold_cnt_reg;
        rep_cnt_next  = rep_cnt_reg;
        press_next    = 1'b0;
        release_next  = 1'b0;
        long_next     = 1'b0;
        repeat_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (sync2_reg) begin
                    state_next  = DB_PRESS;
                    db_cnt_next = DB_ONE;
                end
            end
            DB_PRESS: begin
                if (!sync2_reg) begin
                    state_next = IDLE;
                end else if (db_cnt_reg == DB_MAX) begin
                    state_next    = PRESSED;
                    hold_cnt_next = '0;
                    rep_cnt_next  = '0;
                    press_next    = 1'b1;
                end else begin
                    db_cnt_next = db_cnt_reg + DB_ONE;
                end
            end
            PRESSED: begin
                if (!sync2_reg) begin
                    state_next  = DB_RELEASE;
                    db_cnt_next = DB_ONE;
                end else if (hold_cnt_reg != HOLD_MAX) begin
                    // Hold counter saturates at HOLD_CYCLES, so long fires once per press.
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                    if (hold_cnt_reg == HOLD_LAST) begin
                        long_next    = 1'b1;
                        rep_cnt_next = '0;
                    end
                end else if (REPEAT_CYCLES > 0) begin
                    // Repeat period only advances on PRESSED cycles after long_o.
                    if (rep_cnt_reg == REP_LAST) begin
                        repeat_next  = 1'b1;
                        rep_cnt_next = '0;
                    end else begin
                        rep_cnt_next = rep_cnt_reg + 1'b1;
                    end
                end
            end
            DB_RELEASE: begin
                // Hold and repeat counters stay frozen here.
                if (sync2_reg) begin
                    state_next = PRESSED;
                end else if (db_cnt_reg == DB_MAX) begin
                    state_next   = IDLE;
                    release_next = 1'b1;
                end else begin
                    db_cnt_next = db_cnt_reg + DB_ONE;
                end
            end
            default: state_next = IDLE;
        endcase

        level_next = (state_next == PRESSED) || (state_next == DB_RELEASE);
    end

    assign level_o   = level_reg;
    assign press_o   = press_reg;
    assign release_o = release_reg;
    assign long_o    = long_reg;
    assign repeat_o  = repeat_reg;

endmodule

// File: rtl/button_debounce.sv
// button_debounce: N_CH independent debounced buttons with press, release,
// long-press and auto-repeat pulses.
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset
//   button_i   : raw asynchronous button levels [N_CH]
//   level_o    : debounced levels [N_CH]
//   press_o    : press pulses [N_CH]
//   release_o  : release pulses [N_CH]
//   long_o     : long-press pulses [N_CH]
//   repeat_o   : auto-repeat pulses [N_CH]
module button_debounce
    import button_pkg::*;
#(
    parameter int N_CH            = DEF_N_CH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N_CH-1:0] button_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] long_o,
    output logic [N_CH-1:0] repeat_o
);

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_channel (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .button_i  (button_i[gi]),
            .level_o   (level_o[gi]),
            .press_o   (press_o[gi]),
            .release_o (release_o[gi]),
            .long_o    (long_o[gi]),
            .repeat_o  (repeat_o[gi])
        );
    end

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed scenarios against button_debounce with
// N_CH=4, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3.
// Single-channel scenarios drive channel 0 only.
// Edge numbering: edge 0 is the first rising edge that samples the new raw level;
// outputs are sampled 1 time unit after each edge.
module tb_button_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] button;
    logic [3:0] level_o, press_o, release_o, long_o, repeat_o;

    int errors = 0;
    int checks = 0;

    button_debounce #(
        .N_CH            (4),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (10),
        .REPEAT_CYCLES   (3)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .button_i  (button),
        .level_o   (level_o),
        .press_o   (press_o),
        .release_o (release_o),
        .long_o    (long_o),
        .repeat_o  (repeat_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        button = 4'b0000;
        repeat (12) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        button = 4'b0000;
        step();
        step();
        checks++;
        if ({level_o, press_o, release_o, long_o, repeat_o} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {level_o, press_o, release_o, long_o, repeat_o});
        end
        rst = 1'b0;
        step();
        checks++;
        if (level_o !== 4'b0000) begin
            errors++;
            $display("FAIL reset_level_after: got %b expected 0000", level_o);
        end
        $display("test_reset done");
    endtask

    task automatic test_clean_press();
        logic exp_p, exp_l;
        button = 4'b0001;
        step();                                  // edge 0
        for (int k = 1; k <= 7; k++) begin
            step();
            exp_p = (k == 6);
            exp_l = (k >= 6);
            checks++;
            if (press_o[0] !== exp_p) begin
                errors++;
                $display("FAIL clean_press_pulse edge %0d: got %b expected %b", k, press_o[0], exp_p);
            end
            checks++;
            if (level_o[0] !== exp_l) begin
                errors++;
                $display("FAIL clean_press_level edge %0d: got %b expected %b", k, level_o[0], exp_l);
            end
        end
        button = 4'b0000;
        step();                                  // release edge 0
        for (int k = 1; k <= 7; k++) begin
            step();
            exp_p = (k == 6);
            exp_l = (k < 6);
            checks++;
            if (release_o[0] !== exp_p) begin
                errors++;
                $display("FAIL clean_release_pulse edge %0d: got %b expected %b", k, release_o[0], exp_p);
            end
            checks++;
            if (level_o[0] !== exp_l) begin
                errors++;
                $display("FAIL clean_release_level edge %0d: got %b expected %b", k, level_o[0], exp_l);
            end
        end
        idle();
        $display("test_clean_press done");
    endtask

    task automatic test_bounce();
        logic pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 16; k++) begin
            button[0] = (k < 6) ? pat[k] : 1'b0;
            step();
            checks++;
            if ({press_o[0], level_o[0], release_o[0]} !== 3'b000) begin
                errors++;
                $display("FAIL bounce edge %0d: press/level/release=%b expected 000", k,
                         {press_o[0], level_o[0], release_o[0]});
            end
        end
        idle();
        $display("test_bounce done");
    endtask

    task automatic test_long_repeat();
        logic exp_lg, exp_rp;
        button = 4'b0001;
        step();                                  // edge 0, PRESSED at edge 6
        for (int k = 1; k <= 26; k++) begin
            step();
            exp_lg = (k == 16);
            exp_rp = (k == 19) || (k == 22) || (k == 25);
            checks++;
            if (long_o[0] !== exp_lg) begin
                errors++;
                $display("FAIL long_pulse edge %0d: got %b expected %b", k, long_o[0], exp_lg);
            end
            checks++;
            if (repeat_o[0] !== exp_rp) begin
                errors++;
                $display("FAIL repeat_pulse edge %0d: got %b expected %b", k, repeat_o[0], exp_rp);
            end
        end
        button = 4'b0000;
        step();                                  // release edge 0
        for (int k = 1; k <= 7; k++) begin
            step();
            exp_rp = (k == 6);
            checks++;
            if (release_o[0] !== exp_rp || long_o[0] !== 1'b0) begin
                errors++;
                $display("FAIL long_release edge %0d: release=%b long=%b expected release=%b long=0",
                         k, release_o[0], long_o[0], exp_rp);
            end
        end
        idle();
        $display("test_long_repeat done");
    endtask

    task automatic test_release_glitch();
        logic exp_lg;
        button = 4'b0001;
        step();                                  // edge 0
        repeat (7) step();                       // edges 1..7
        checks++;
        if (level_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL glitch_pressed: level got %b expected 1", level_o[0]);
        end
        for (int k = 8; k <= 20; k++) begin
            button[0] = (k == 8 || k == 9) ? 1'b0 : 1'b1;
            step();
            // hold count is frozen in the 2 DB_RELEASE cycles, so long lands on edge 19
            exp_lg = (k == 19);
            checks++;
            if ({press_o[0], release_o[0], level_o[0]} !== 3'b001) begin
                errors++;
                $display("FAIL glitch edge %0d: press/release/level=%b expected 001", k,
                         {press_o[0], release_o[0], level_o[0]});
            end
            checks++;
            if (long_o[0] !== exp_lg) begin
                errors++;
                $display("FAIL glitch_long edge %0d: got %b expected %b", k, long_o[0], exp_lg);
            end
        end
        idle();
        $display("test_release_glitch done");
    endtask

    task automatic test_multi_channel();
        logic [3:0] exp_p, exp_l;
        button = 4'b1001;
        step();                                  // edge 0
        for (int k = 1; k <= 7; k++) begin
            step();
            exp_p = (k == 6) ? 4'b1001 : 4'b0000;
            exp_l = (k >= 6) ? 4'b1001 : 4'b0000;
            checks++;
            if (press_o !== exp_p) begin
                errors++;
                $display("FAIL multi_press edge %0d: got %b expected %b", k, press_o, exp_p);
            end
            checks++;
            if (level_o !== exp_l) begin
                errors++;
                $display("FAIL multi_level edge %0d: got %b expected %b", k, level_o, exp_l);
            end
        end
        button = 4'b0000;
        step();
        for (int k = 1; k <= 7; k++) begin
            step();
            exp_p = (k == 6) ? 4'b1001 : 4'b0000;
            checks++;
            if (release_o !== exp_p) begin
                errors++;
                $display("FAIL multi_release edge %0d: got %b expected %b", k, release_o, exp_p);
            end
        end
        idle();
        $display("test_multi_channel done");
    endtask

    task automatic test_reset_mid_hold();
        logic exp_p, exp_l;
        button = 4'b0001;
        step();                                  // edge 0
        repeat (7) step();                       // edges 1..7
        checks++;
        if (level_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_hold_pressed: level got %b expected 1", level_o[0]);
        end
        rst = 1'b1;
        step();                                  // edge 8 resets
        rst = 1'b0;
        checks++;
        if ({level_o, press_o, release_o, long_o, repeat_o} !== 20'h0) begin
            errors++;
            $display("FAIL rst_hold_outputs: got %h expected 0", {level_o, press_o, release_o, long_o, repeat_o});
        end
        // edge 9 is the new edge 0, so PRESSED again at edge 15
        for (int k = 9; k <= 16; k++) begin
            step();
            exp_p = (k == 15);
            exp_l = (k >= 15);
            checks++;
            if (press_o[0] !== exp_p || release_o[0] !== 1'b0) begin
                errors++;
                $display("FAIL rst_hold_repress edge %0d: press=%b release=%b expected press=%b release=0",
                         k, press_o[0], release_o[0], exp_p);
            end
            checks++;
            if (level_o[0] !== exp_l) begin
                errors++;
                $display("FAIL rst_hold_level edge %0d: got %b expected %b", k, level_o[0], exp_l);
            end
        end
        idle();
        $display("test_reset_mid_hold done");
    endtask

    initial begin
        rst = 1'b1;
        button = 4'b0000;
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_repeat();
        test_release_glitch();
        test_multi_channel();
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
